tmds_channel_decoder: RTL
=========================

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SEARCH_TIMEOUT, 4096: cycles without a control token before the window offset advances in SEARCH.
- LOCK_RUN, 8: consecutive control tokens required to declare lock.
- LOSS_TIMEOUT, 65536: cycles without a control token before lock is dropped.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- pclk, in, 1: pixel clock; the only clock.
- reset, in, 1: synchronous, active-high reset.
- din, in, 10: raw deserialized TMDS word, one per pclk, bit 0 first on the wire.
- dout, out, 8: decoded pixel byte.
- c0, out, 1: control bit 0 (hsync on the blue channel).
- c1, out, 1: control bit 1 (vsync on the blue channel).
- de, out, 1: data enable.
- locked, out, 1: word alignment established.
- offset, out, 4: current bit-window offset, 0..9.

Function
REQ-003 The block SHALL register each din into prev and form a 20-bit concat {din, prev}; the aligned word SHALL be concat[offset+9 : offset].
REQ-004 The aligned word SHALL be registered into aw at the same edge din is sampled; outputs SHALL be registered from aw one edge later (din at edge n -> outputs valid after edge n+1).
REQ-005 aw SHALL be a control token iff it equals one of these values: 10'b1101010100 (c1c0=00), 10'b0010101011 (01), 10'b0101010100 (10), 10'b1010101011 (11).
REQ-006 Data decode SHALL work as follows:
- d = aw[9] ? ~aw[7:0] : aw[7:0].
- dout[0] = d[0].
- For i = 1..7: dout[i] = d[i]^d[i-1] when aw[8]=1, else ~(d[i]^d[i-1]).
REQ-007 When locked=1 and aw is a token: de=0, c1/c0 = the token code, dout=0.
REQ-008 When locked=1 and aw is not a token: de=1, dout = the decoded byte, c0/c1 hold their last values.
REQ-009 When locked=0: de=0, dout=0, c0=c1=0.
REQ-010 The FSM SHALL have three states: SEARCH, CHECK and LOCKED.
REQ-011 In SEARCH:
- A cycle counter SHALL count cycles with no token in aw.
- On a token, the FSM SHALL go to CHECK with run count=1.
- When the counter reaches SEARCH_TIMEOUT-1 with no token, offset SHALL increment (9 wraps to 0) and the counter SHALL clear.
- If a token and the timeout occur in the same cycle, the token SHALL win.
REQ-012 In CHECK, offset SHALL be held:
- Each token SHALL increment the run count; when the run count reaches LOCK_RUN, the FSM SHALL go to LOCKED and locked SHALL be 1 from the next cycle.
- Any non-token SHALL return the FSM to SEARCH with offset+1 (wrapping) and cleared counters.
REQ-013 In LOCKED:
- Each token SHALL clear the loss counter.
- After LOSS_TIMEOUT consecutive non-token cycles, the FSM SHALL go to SEARCH, locked SHALL be 0, and offset SHALL be retained (search resumes from it).
REQ-014 Counter widths SHALL be sized from the parameters; counters SHALL saturate and never wrap in between their clear conditions.
REQ-015 An offset change SHALL take effect on the next sampled din; no output glitch handling is required beyond locked=0.

Reset
REQ-016 While reset=1 at a pclk edge, the following SHALL hold one edge later:
- state=SEARCH, offset=0.
- All counters=0, prev=0, aw=0.
- dout=0, c0=c1=0, de=0, locked=0.
REQ-017 A reset asserted in any state, mid-run or mid-lock, SHALL override all other transitions in that cycle.

Verification (SEARCH_TIMEOUT=16, LOCK_RUN=4, LOSS_TIMEOUT=32)
REQ-018 Aligned stream: drive 10'b1101010100 continuously after reset -> locked=1 within 7 cycles, offset=0, de=0, c0=0, c1=0.
REQ-019 Misaligned stream: drive a continuous token bitstream delayed by 3 bits -> offset steps 0,1,2,3 at 16-cycle intervals, then locked=1 with offset=3.
REQ-020 Decode check while locked at offset 0:
- din=10'b0100000000 -> dout=8'h00, de=1, two edges later.
- din=10'b1011111111 -> dout=8'hFE.
- Return to token 10'b1010101011 -> de=0, c0=1, c1=1.
REQ-021 Lock qualification: in CHECK, drive 2 tokens then 1 data word -> FSM returns to SEARCH, offset=1, locked stays 0.
REQ-022 Loss of lock:
- 31 consecutive data words -> locked stays 1.
- The 32nd data word -> locked=0, state SEARCH, offset unchanged.
REQ-023 Reset mid-lock: assert reset for 1 cycle while locked -> all outputs 0, offset=0 next cycle; relock follows REQ-018.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: recovers 10-bit word alignment from control-token runs,
// then decodes data bytes and control codes from the aligned word.
module tmds_channel_decoder #(
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned LOCK_RUN       = 8,
  parameter int unsigned LOSS_TIMEOUT   = 65536
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic [9:0] din,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int unsigned SrchW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int unsigned RunW  = (LOCK_RUN > 0) ? $clog2(LOCK_RUN + 1) : 1;
  localparam int unsigned LossW = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

  localparam logic [SrchW-1:0] SrchLast = SrchW'(SEARCH_TIMEOUT - 1);
  localparam logic [RunW-1:0]  RunDone  = RunW'(LOCK_RUN);
  localparam logic [LossW-1:0] LossLast = LossW'(LOSS_TIMEOUT - 1);

  localparam logic [9:0] Tok00 = 10'b1101010100;
  localparam logic [9:0] Tok01 = 10'b0010101011;
  localparam logic [9:0] Tok10 = 10'b0101010100;
  localparam logic [9:0] Tok11 = 10'b1010101011;

  typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

  state_e           state_q, state_d;
  logic [3:0]       offset_q, offset_d;
  logic [SrchW-1:0] srch_q, srch_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [LossW-1:0] loss_q, loss_d;
  logic [9:0]       prev_q;
  logic [9:0]       aw_q, aw_d;
  logic [7:0]       dout_q, dout_d;
  logic             c0_q, c0_d;
  logic             c1_q, c1_d;
  logic             de_q, de_d;

  logic [19:0] concat;
  logic [3:0]  offset_inc;
  logic        is_tok;
  logic [1:0]  tok_code;
  logic [7:0]  d_sel;
  logic [7:0]  dec;
  logic        lock_d;

  // Window slides across the current and previous word; offset 0 selects prev.
  assign concat = {din, prev_q};

  always_comb begin
    aw_d = concat[9:0];
    for (int k = 1; k < 10; k++) begin
      if (offset_q == 4'(k)) aw_d = concat[k +: 10];
    end
  end

  assign offset_inc = (offset_q >= 4'd9) ? 4'd0 : offset_q + 4'd1;

  always_comb begin
    is_tok   = 1'b1;
    tok_code = 2'b00;
    case (aw_q)
      Tok00:   tok_code = 2'b00;
      Tok01:   tok_code = 2'b01;
      Tok10:   tok_code = 2'b10;
      Tok11:   tok_code = 2'b11;
      default: is_tok   = 1'b0;
    endcase
  end

  always_comb begin
    d_sel  = aw_q[9] ? ~aw_q[7:0] : aw_q[7:0];
    dec    = '0;
    dec[0] = d_sel[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = aw_q[8] ? (d_sel[i] ^ d_sel[i-1]) : ~(d_sel[i] ^ d_sel[i-1]);
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    srch_d   = srch_q;
    run_d    = run_q;
    loss_d   = loss_q;
    unique case (state_q)
      StSearch: begin
        // A token arriving on the timeout cycle takes priority over the slide.
        if (is_tok) begin
          srch_d  = '0;
          run_d   = RunW'(1);
          loss_d  = '0;
          state_d = (LOCK_RUN <= 1) ? StLocked : StCheck;
        end else if (srch_q >= SrchLast) begin
          offset_d = offset_inc;
          srch_d   = '0;
        end else begin
          srch_d = srch_q + SrchW'(1);
        end
      end
      StCheck: begin
        if (is_tok) begin
          if (run_q < RunDone) run_d = run_q + RunW'(1);
          if (run_q + RunW'(1) >= RunDone) begin
            state_d = StLocked;
            loss_d  = '0;
          end
        end else begin
          state_d  = StSearch;
          offset_d = offset_inc;
          srch_d   = '0;
          run_d    = '0;
        end
      end
      StLocked: begin
        if (is_tok) begin
          loss_d = '0;
        end else if (loss_q >= LossLast) begin
          state_d = StSearch;
          srch_d  = '0;
          run_d   = '0;
          loss_d  = '0;
        end else begin
          loss_d = loss_q + LossW'(1);
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Gate outputs with the next lock state so they agree with `locked` every cycle.
  assign lock_d = (state_d == StLocked);

  always_comb begin
    dout_d = '0;
    de_d   = 1'b0;
    c0_d   = c0_q;
    c1_d   = c1_q;
    if (!lock_d) begin
      c0_d = 1'b0;
      c1_d = 1'b0;
    end else if (is_tok) begin
      c1_d = tok_code[1];
      c0_d = tok_code[0];
    end else begin
      de_d   = 1'b1;
      dout_d = dec;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q  <= StSearch;
      offset_q <= '0;
      srch_q   <= '0;
      run_q    <= '0;
      loss_q   <= '0;
      prev_q   <= '0;
      aw_q     <= '0;
      dout_q   <= '0;
      c0_q     <= 1'b0;
      c1_q     <= 1'b0;
      de_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      srch_q   <= srch_d;
      run_q    <= run_d;
      loss_q   <= loss_d;
      prev_q   <= din;
      aw_q     <= aw_d;
      dout_q   <= dout_d;
      c0_q     <= c0_d;
      c1_q     <= c1_d;
      de_q     <= de_d;
    end
  end

  assign dout   = dout_q;
  assign c0     = c0_q;
  assign c1     = c1_q;
  assign de     = de_q;
  assign locked = (state_q == StLocked);
  assign offset = offset_q;

endmodule
